// File: rtl/mux_scan_ctrl_if.sv
// rtl/mux_scan_ctrl_if.sv - host and mux-side signal bundle for the scan controller
interface mux_scan_ctrl_if;
  logic        start;
  logic [15:0] data_in;
  logic [3:0]  In1;
  logic [3:0]  In2;
  logic [3:0]  In3;
  logic [3:0]  In4;
  logic [1:0]  sel1;
  logic [1:0]  sel2;
  logic        Y_L;
  logic        busy;
  logic        done;
  logic [15:0] data_out;
  logic        mismatch;

  modport master (
    output start, data_in, Y_L,
    input  In1, In2, In3, In4, sel1, sel2, busy, done, data_out, mismatch
  );

  modport slave (
    input  start, data_in, Y_L,
    output In1, In2, In3, In4, sel1, sel2, busy, done, data_out, mismatch
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - sweeps a 16:1 mux select, samples Y_L and rebuilds the word
module mux_scan_ctrl #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  mux_scan_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  index;
  logic [3:0]  cnt;
  logic [15:0] word;
  logic [15:0] shadow;
  logic        busy_q;
  logic        done_q;
  logic [15:0] data_out_q;
  logic        mismatch_q;

  // The select lines always equal the bit index, which only moves on a SAMPLE
  // edge, so the mux sees a stable address for the whole settle window.
  assign bus.In1      = word[3:0];
  assign bus.In2      = word[7:4];
  assign bus.In3      = word[11:8];
  assign bus.In4      = word[15:12];
  assign bus.sel1     = index[1:0];
  assign bus.sel2     = index[3:2];
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.data_out = data_out_q;
  assign bus.mismatch = mismatch_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SETTLE;
      SETTLE:  if (cnt == CNT_LAST) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = (index == 4'd15) ? DONE : SETTLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch word, step index/counter, capture samples, publish result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word       <= '0;
      index      <= '0;
      cnt        <= '0;
      shadow     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      data_out_q <= '0;
      mismatch_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            word   <= bus.data_in;
            index  <= '0;
            cnt    <= '0;
            shadow <= '0;
            busy_q <= 1'b1;
          end
        end
        SETTLE: begin
          cnt <= cnt + 4'd1;
        end
        SAMPLE: begin
          shadow[index] <= ~bus.Y_L;
          if (index == 4'd15) begin
            busy_q <= 1'b0;
          end else begin
            index <= index + 4'd1;
            cnt   <= '0;
          end
        end
        DONE: begin
          // Bit 15 was written on the previous SAMPLE edge, so shadow is complete here.
          data_out_q <= shadow;
          mismatch_q <= (shadow != word);
          done_q     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - self-checking bench for mux_scan_ctrl with a behavioural scan model
module tb_mux_scan_ctrl;
  localparam int S0 = 1;
  localparam int S1 = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] din = '0;
  logic        yl_fault = 1'b0;
  logic        chk_en = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  mux_scan_ctrl_if b0 ();
  mux_scan_ctrl_if b1 ();

  logic [15:0] w0;
  logic [15:0] w1;

  assign b0.start   = start;
  assign b0.data_in = din;
  assign b1.start   = start;
  assign b1.data_in = din;
  assign w0 = {b0.In4, b0.In3, b0.In2, b0.In1};
  assign w1 = {b1.In4, b1.In3, b1.In2, b1.In1};
  assign b0.Y_L = yl_fault ? 1'b1 : ~w0[{b0.sel2, b0.sel1}];
  assign b1.Y_L = ~w1[{b1.sel2, b1.sel1}];

  mux_scan_ctrl #(.SETTLE_CYCLES(S0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  mux_scan_ctrl #(.SETTLE_CYCLES(S1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  always #5 clk = ~clk;

  bit          m_act [2];
  int          m_k   [2];
  logic [15:0] m_word[2];
  logic [15:0] m_dout[2];
  logic [3:0]  m_sel [2];
  logic        m_busy[2];
  logic        m_done[2];
  logic        m_mis [2];
  logic        m_flt [2];

  function automatic int per(input int i);
    return ((i == 0) ? S0 : S1) + 1;
  endfunction

  // Scan model: after an accepted start, edge k shows sel = k/(S+1) (max 15),
  // busy until 16*(S+1), done exactly at 16*(S+1)+1.
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_act[i] = 1'b0; m_k[i] = 0; m_word[i] = '0; m_dout[i] = '0;
        m_sel[i] = '0; m_busy[i] = 1'b0; m_done[i] = 1'b0; m_mis[i] = 1'b0; m_flt[i] = 1'b0;
      end else begin
        m_done[i] = 1'b0;
        if (m_act[i]) begin
          m_k[i] = m_k[i] + 1;
          m_sel[i] = (m_k[i] / per(i) > 15) ? 4'd15 : 4'(m_k[i] / per(i));
          m_busy[i] = (m_k[i] < 16 * per(i));
          if (m_k[i] == 16 * per(i) + 1) begin
            m_act[i]  = 1'b0;
            m_done[i] = 1'b1;
            m_dout[i] = m_flt[i] ? 16'h0000 : m_word[i];
            m_mis[i]  = (m_dout[i] != m_word[i]);
          end
        end else if (start) begin
          m_act[i] = 1'b1; m_k[i] = 0; m_word[i] = din; m_sel[i] = '0;
          m_busy[i] = 1'b1; m_flt[i] = (i == 0) && yl_fault;
        end
      end
    end
  end

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle compare of both DUTs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("u0.in", w0, m_word[0]);
      check("u0.sel", 16'({b0.sel2, b0.sel1}), 16'(m_sel[0]));
      check("u0.busy", 16'(b0.busy), 16'(m_busy[0]));
      check("u0.done", 16'(b0.done), 16'(m_done[0]));
      check("u0.data_out", b0.data_out, m_dout[0]);
      check("u0.mismatch", 16'(b0.mismatch), 16'(m_mis[0]));
      check("u1.in", w1, m_word[1]);
      check("u1.sel", 16'({b1.sel2, b1.sel1}), 16'(m_sel[1]));
      check("u1.busy", 16'(b1.busy), 16'(m_busy[1]));
      check("u1.done", 16'(b1.done), 16'(m_done[1]));
      check("u1.data_out", b1.data_out, m_dout[1]);
      check("u1.mismatch", 16'(b1.mismatch), 16'(m_mis[1]));
    end
  end

  int          d_at [2];
  int          d_cnt[2];
  logic [15:0] d_out[2];
  logic        d_mis[2];

  // Runs a fixed number of edges (e = 0 is the start-sampling edge), recording done pulses
  task automatic run(input int edges, input bit pulse);
    d_at[0] = -1; d_at[1] = -1; d_cnt[0] = 0; d_cnt[1] = 0;
    for (int e = 0; e < edges; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (pulse && e == 0) start = 1'b0;
      if (b0.done) begin
        if (d_cnt[0] == 0) begin d_at[0] = e; d_out[0] = b0.data_out; d_mis[0] = b0.mismatch; end
        d_cnt[0]++;
      end
      if (b1.done) begin
        if (d_cnt[1] == 0) begin d_at[1] = e; d_out[1] = b1.data_out; d_mis[1] = b1.mismatch; end
        d_cnt[1]++;
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset.busy", 16'(b0.busy), 16'h0);
    check("reset.in", w0, 16'h0000);
    check("reset.data_out", b0.data_out, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    din = 16'h4B3C; start = 1'b1;
    run(70, 1'b1);
    check("a.done_edge0", 16'(d_at[0]), 16'd33);
    check("a.done_count0", 16'(d_cnt[0]), 16'd1);
    check("a.data_out0", d_out[0], 16'h4B3C);
    check("a.mismatch0", 16'(d_mis[0]), 16'h0);
    check("a.done_edge1", 16'(d_at[1]), 16'd65);
    check("a.data_out1", d_out[1], 16'h4B3C);
    check("a.In1", 16'(b0.In1), 16'hC);
    check("a.In2", 16'(b0.In2), 16'h3);
    check("a.In3", 16'(b0.In3), 16'hB);
    check("a.In4", 16'(b0.In4), 16'h4);
    check("a.sel_hold", 16'({b0.sel2, b0.sel1}), 16'd15);

    din = 16'hFFFC; start = 1'b1;
    run(34, 1'b0);
    check("b.done_edge0", 16'(d_at[0]), 16'd33);
    check("b.done_count0", 16'(d_cnt[0]), 16'd1);
    check("b.data_out0", d_out[0], 16'hFFFC);
    check("b.mismatch0", 16'(d_mis[0]), 16'h0);
    @(posedge clk);
    @(negedge clk);
    check("b.retrigger_busy", 16'(b0.busy), 16'h1);
    start = 1'b0;
    run(90, 1'b0);

    yl_fault = 1'b1; din = 16'h4B3C; start = 1'b1;
    run(70, 1'b1);
    check("c.data_out0", d_out[0], 16'h0000);
    check("c.mismatch0", 16'(d_mis[0]), 16'h1);
    check("c.data_out1", d_out[1], 16'h4B3C);
    check("c.mismatch1", 16'(d_mis[1]), 16'h0);
    yl_fault = 1'b0;

    din = 16'h1234; start = 1'b1;
    run(15, 1'b1);
    check("d.sel_at_abort", 16'({b0.sel2, b0.sel1}), 16'd7);
    #2 rst_n = 1'b0;
    #1;
    check("d.async_busy", 16'(b0.busy), 16'h0);
    check("d.async_in", w0, 16'h0000);
    check("d.async_sel", 16'({b0.sel2, b0.sel1}), 16'd0);
    check("d.async_data_out", b0.data_out, 16'h0000);
    check("d.async_mismatch", 16'(b0.mismatch), 16'h0);
    check("d.async_busy1", 16'(b1.busy), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run(40, 1'b0);
    check("d.no_done0", 16'(d_cnt[0]), 16'd0);
    check("d.no_done1", 16'(d_cnt[1]), 16'd0);
    din = 16'hA5A5; start = 1'b1;
    run(70, 1'b1);
    check("d.data_out0", d_out[0], 16'hA5A5);
    check("d.mismatch0", 16'(d_mis[0]), 16'h0);

    din = 16'h8001; start = 1'b1;
    run(70, 1'b1);
    check("e.done_edge1", 16'(d_at[1]), 16'd65);
    check("e.data_out1", d_out[1], 16'h8001);
    check("e.mismatch1", 16'(d_mis[1]), 16'h0);
    check("e.done_edge0", 16'(d_at[0]), 16'd33);
    check("e.data_out0", d_out[0], 16'h8001);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
- Sequencer and capture stage wrapped around the MUX16to1 datapath.
- Latches a 16-bit word and drives it onto the mux data inputs (In1..In4).
- Sweeps the two-level select lines (sel2, sel1) through all 16 positions and samples the active-low mux output Y_L at each position.
- Reassembles the sampled bits into a word, flags any mismatch against the latched word, and signals completion with a one-cycle pulse.

Parameters:
- SETTLE_CYCLES, 1, cycles held at each select value before sampling Y_L; legal range 1..15.

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request a scan; honoured only in IDLE
- data_in  input  16  word to scan; latched on an accepted start
- In1  output  4  latched word [3:0] to the mux
- In2  output  4  latched word [7:4]
- In3  output  4  latched word [11:8]
- In4  output  4  latched word [15:12]
- sel1  output  2  first-level select = bit index [1:0]
- sel2  output  2  second-level select = bit index [3:2]
- Y_L  input  1  mux output, active-low: Y_L = ~word[{sel2,sel1}]
- busy  output  1  high from the accepted start through the last SAMPLE cycle
- done  output  1  one-cycle pulse when data_out and mismatch are valid
- data_out  output  16  reassembled word
- mismatch  output  1  data_out != latched word; valid from the done pulse until the next done

Behaviour:
- Reset (asynchronous assert, synchronous release on the first clk edge with rst_n high):
  - state = IDLE; In1..In4 = 0; sel1 = sel2 = 0.
  - busy = 0, done = 0, data_out = 0, mismatch = 0.
  - Internal index, settle counter and shadow register = 0.
- Reset mid-scan aborts the scan immediately and discards partial results; no done pulse is produced.
- States: IDLE, SETTLE, SAMPLE, DONE. Every output is registered.
- IDLE:
  - On start = 1: latch data_in into In1..In4, set index = 0, settle counter = 0, busy = 1, go to SETTLE.
  - done = 0 in every IDLE cycle except the DONE -> IDLE transition cycle (see DONE).
- SETTLE:
  - {sel2,sel1} = index throughout; counter increments each cycle.
  - When counter == SETTLE_CYCLES-1, go to SAMPLE.
- SAMPLE:
  - shadow[index] <= ~Y_L.
  - If index == 15, go to DONE.
  - Else index increments, counter clears, go to SETTLE; sel updates on this same edge.
- DONE (exactly 1 cycle):
  - data_out <= shadow with the final bit merged, so bit 15 is not lost.
  - mismatch <= (merged shadow != latched word).
  - done <= 1 and busy <= 0, registered on entry, so done is high in the cycle after DONE.
  - Then go to IDLE.
- start is ignored while busy or in DONE; it is not queued.
- A start held high continuously re-triggers on the first IDLE cycle after done.
- In1..In4 stay stable for the whole scan and hold the last word afterwards.
- sel holds at 15 after the scan until the next start.
- Latency: with start sampled at edge E0, done is high in the cycle following edge E0 + 16*(SETTLE_CYCLES+1) + 1.
  - SETTLE_CYCLES = 1: 33 edges.
  - SETTLE_CYCLES = 3: 65 edges.
- data_out and mismatch hold their values until the next DONE.
- Y_L is treated as combinational from In/sel; its value is sampled only in SAMPLE.

Test Plan:
- Reset: assert rst_n = 0 mid-clock -> all outputs 0 immediately, without waiting for a clock edge.
- Scan 0x4B3C, SETTLE_CYCLES = 1, real MUX16to1 instance on the outputs:
  - In1 = 4'b1100, In2 = 4'b0011, In3 = 4'b1011, In4 = 4'b0100.
  - sel steps 0..15, each value held 2 cycles.
  - done pulses once, 33 edges after start; data_out = 0x4B3C, mismatch = 0.
- Scan 0xFFFC with start held high throughout:
  - Extra starts during busy are ignored.
  - data_out = 0xFFFC, mismatch = 0.
  - A second scan begins on the first IDLE cycle after done.
- Fault: replace the mux with Y_L tied to 1, scan 0x4B3C -> data_out = 0x0000, mismatch = 1.
- Reset mid-scan at index 7:
  - No done pulse; outputs return to reset values.
  - A following scan of 0xA5A5 gives data_out = 0xA5A5, mismatch = 0.
- SETTLE_CYCLES = 3, scan 0x8001 -> each sel held 4 cycles, done 65 edges after start, data_out = 0x8001.
